// File: rtl/serial_loader.sv
// Serial-to-parallel word collector (MSB first) with a one-cycle load strobe for a holding register.
// Define PARITY_CHECK_EN to expect an even-parity bit after each word and suppress the load on mismatch.
module serial_loader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             load_en,
  output logic             busy,
  output logic             parity_err
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             load_nxt;
  logic             perr_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    data_nxt  = data_out;
    load_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shift_nxt = {shift[WIDTH-2:0], bit_in};
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
            state_nxt = PARITY;
`else
            state_nxt = IDLE;
            data_nxt  = {shift[WIDTH-2:0], bit_in};
            load_nxt  = 1'b1;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        // shift holds the complete word here; even parity means bit_in equals its XOR
        if (bit_valid) begin
          state_nxt = IDLE;
          if (bit_in == ^shift) begin
            data_nxt = shift;
            load_nxt = 1'b1;
          end else begin
            perr_nxt = 1'b1;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      data_out   <= '0;
      load_en    <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shift      <= shift_nxt;
      data_out   <= data_nxt;
      load_en    <= load_nxt;
      busy       <= (state_nxt != IDLE);
      parity_err <= perr_nxt;
    end
  end

endmodule
